tile_blitter: RTL and testbench
===============================

TILE_BLITTER -- requirements
Module: tile_blitter

Interface
REQ-001 SHALL have parameter TILE_COLS, 13, number of tile columns on the 96x64 display.
REQ-002 SHALL have parameter TILE_ROWS, 9, number of tile rows.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  draw request present.
REQ-006 SHALL have port req_ready  output  1  high only in IDLE.
REQ-007 SHALL have port req_col  input  4  tile column.
REQ-008 SHALL have port req_row  input  4  tile row.
REQ-009 SHALL have port req_wall  input  4  wall code; nonzero selects wall texture.
REQ-010 SHALL have port req_special  input  3  special code (1 curse, 2 heart, 3 powerup, 4 enemy), used when req_wall==0.
REQ-011 SHALL have port req_transp  input  1  1 = skip texels equal to 0.
REQ-012 SHALL have port tex_wall_sel  output  4  to texture ROM wall_selector.
REQ-013 SHALL have port tex_special_sel  output  3  to texture ROM special_selector.
REQ-014 SHALL have port tex_pos  output  6  to texture ROM pos_selector.
REQ-015 SHALL have port tex_data  input  4  texture ROM output; combinational from the tex_* selectors, same cycle.
REQ-016 SHALL have port wr_valid, wr_ready  output/input  1  pixel write handshake.
REQ-017 SHALL have ports wr_x  output  7, wr_y  output  6, wr_data  output  4  pixel address and colour code.
REQ-018 SHALL have port done  output  1  one-cycle pulse at request completion.
REQ-019 SHALL have port err  output  1  one-cycle pulse, concurrent with done, for out-of-range tiles.

Function
REQ-020 SHALL implement states IDLE, DRAW, DONE.
REQ-021 IDLE: req_valid && req_ready SHALL latch all req_* fields; next state DRAW with r=0, c=0, or DONE with err when req_col>=TILE_COLS or req_row>=TILE_ROWS.
REQ-022 tex_wall_sel and tex_special_sel SHALL be driven from the latched fields, held stable throughout DRAW.
REQ-023 tex_pos SHALL equal 48 - (7*r + c), with r,c in 0..6 (r=0 top row, c=0 leftmost).
REQ-024 In DRAW, wr_x SHALL equal col*7+c, wr_y SHALL equal row*7+r, and wr_data SHALL equal tex_data.
REQ-025 In DRAW, wr_valid SHALL be high unless transp==1 and tex_data==0 (skip).
REQ-026 The texel SHALL advance when wr_valid&&wr_ready or skip holds: c+1; at c==6, c=0 and r+1.
REQ-027 wr_x, wr_y and wr_data SHALL stay stable while wr_valid && !wr_ready.
REQ-028 Advancing from r=6,c=6 SHALL enter DONE; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-029 Latency SHALL be: opaque tile with wr_ready tied high = 49 DRAW cycles, done on the 50th cycle after acceptance; fully transparent empty tile = 49 DRAW cycles, zero writes.
REQ-030 Outside DRAW, wr_valid SHALL be 0; done and err SHALL be 0 outside DONE.
REQ-031 No new request SHALL be accepted in DRAW or DONE; req_valid there is ignored without loss (source holds).
REQ-032 req_wall!=0 && req_special!=0: wall SHALL take priority (ROM mux behaviour).

Reset
REQ-033 rst_n low SHALL immediately force IDLE, r=c=0, latched fields 0, wr_valid=0, done=0, err=0, req_ready=1 after release.
REQ-034 Reset mid-DRAW SHALL abandon the tile; partially written pixels SHALL NOT be replayed.

Verification
REQ-035 Scenario: col=0,row=0,wall=15,transp=0,wr_ready=1 -> 49 writes; first (0,0,0x0), (1,0,0xF) in row 0, raster order; done at cycle 50.
REQ-036 Scenario: col=12,row=8,special=2 (heart),transp=1 -> only nonzero texels written, each wr_data=0x6, x in 84..90, y in 56..62; done once.
REQ-037 Scenario: wr_ready toggling 1-0-1 every cycle -> outputs held while stalled; exactly 49 writes; no duplicate or skipped coordinates.
REQ-038 Scenario: col=13,row=0 -> req accepted, no wr_valid, done and err pulse next cycle, req_ready high after.
REQ-039 Scenario: rst_n pulsed low mid-DRAW at texel 20 -> wr_valid drops asynchronously, IDLE, next request starts from r=c=0.
REQ-040 Scenario: req_valid held high across two tiles -> second tile accepted only in the IDLE cycle after done.

Source files
------------

// File: rtl/tile_blitter.sv
// Tile blitter: walks a 7x7 texture tile in raster order and emits one pixel
// write per opaque texel into the 96x64 frame buffer address space.
module tile_blitter #(
  parameter int TILE_COLS = 13,
  parameter int TILE_ROWS = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_col,
  input  logic [3:0] req_row,
  input  logic [3:0] req_wall,
  input  logic [2:0] req_special,
  input  logic       req_transp,
  output logic [3:0] tex_wall_sel,
  output logic [2:0] tex_special_sel,
  output logic [5:0] tex_pos,
  input  logic [3:0] tex_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [6:0] wr_x,
  output logic [5:0] wr_y,
  output logic [3:0] wr_data,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] r_q, c_q, r_d, c_d;
  logic [3:0] col_q, row_q, wall_q;
  logic [2:0] special_q;
  logic       transp_q;
  logic       err_q;

  logic accept;
  logic out_of_range;
  logic skip;
  logic advance;

  assign req_ready    = (state_q == IDLE);
  assign accept       = req_valid && req_ready;
  assign out_of_range = (int'(req_col) >= TILE_COLS) || (int'(req_row) >= TILE_ROWS);

  // Texel selection; the ROM answers combinationally in the same cycle.
  assign tex_wall_sel    = wall_q;
  assign tex_special_sel = special_q;
  assign tex_pos         = 6'd48 - (6'(r_q) * 6'd7 + 6'(c_q));

  // A transparent zero texel is consumed without a write in the same cycle.
  assign skip     = transp_q && (tex_data == 4'h0);
  assign wr_valid = (state_q == DRAW) && !skip;
  assign advance  = (state_q == DRAW) && (skip || wr_ready);

  // Coordinates depend only on registered state, so they hold through stalls.
  assign wr_x    = 7'(col_q) * 7'd7 + 7'(c_q);
  assign wr_y    = 6'(row_q) * 6'd7 + 6'(r_q);
  assign wr_data = tex_data;

  assign done = (state_q == DONE);
  assign err  = (state_q == DONE) && err_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          r_d     = 3'd0;
          c_d     = 3'd0;
          state_d = out_of_range ? DONE : DRAW;
        end
      end
      DRAW: begin
        if (advance) begin
          if (c_q == 3'd6) begin
            c_d = 3'd0;
            if (r_q == 3'd6) begin
              r_d     = 3'd0;
              state_d = DONE;
            end else begin
              r_d = r_q + 3'd1;
            end
          end else begin
            c_d = c_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= 3'd0;
      c_q     <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  // Request fields are captured once on acceptance and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= 4'd0;
      row_q     <= 4'd0;
      wall_q    <= 4'd0;
      special_q <= 3'd0;
      transp_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      col_q     <= req_col;
      row_q     <= req_row;
      wall_q    <= req_wall;
      special_q <= req_special;
      transp_q  <= req_transp;
      err_q     <= out_of_range;
    end
  end

endmodule

// File: tb/tb_tile_blitter.sv
// Directed bench for tile_blitter: a behavioural texture ROM feeds the DUT and
// a per-tile scoreboard queue holds the pixel writes each request must produce.
module tb_tile_blitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_col, req_row, req_wall;
  logic [2:0] req_special;
  logic       req_transp;
  logic [3:0] tex_wall_sel;
  logic [2:0] tex_special_sel;
  logic [5:0] tex_pos;
  logic [3:0] tex_data;
  logic       wr_valid, wr_ready;
  logic [6:0] wr_x;
  logic [5:0] wr_y;
  logic [3:0] wr_data;
  logic       done, err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [6:0] x;
    logic [5:0] y;
    logic [3:0] d;
  } wr_t;

  always #5 clk = ~clk;

  tile_blitter #(.TILE_COLS(13), .TILE_ROWS(9)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_col        (req_col),
    .req_row        (req_row),
    .req_wall       (req_wall),
    .req_special    (req_special),
    .req_transp     (req_transp),
    .tex_wall_sel   (tex_wall_sel),
    .tex_special_sel(tex_special_sel),
    .tex_pos        (tex_pos),
    .tex_data       (tex_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_x           (wr_x),
    .wr_y           (wr_y),
    .wr_data        (wr_data),
    .done           (done),
    .err            (err)
  );

  // Texture ROM model: wall has priority; heart is 0x6 on every third texel.
  function automatic logic [3:0] texel(logic [3:0] w, logic [2:0] s, logic [5:0] pos);
    if (w != 4'h0) return (pos[2:0] == 3'd0) ? 4'h0 : w;
    case (s)
      3'd2:             return (pos % 6'd3 == 6'd1) ? 4'h6 : 4'h0;
      3'd1, 3'd3, 3'd4: return pos[0] ? {1'b0, s} : 4'h0;
      default:          return 4'h0;
    endcase
  endfunction

  assign tex_data = texel(tex_wall_sel, tex_special_sel, tex_pos);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after the
  // negedge following done (or right after an in-flight reset when abort_at>=0).
  task automatic run_tile(input logic [3:0] col, input logic [3:0] row,
                          input logic [3:0] wall, input logic [2:0] special,
                          input logic transp, input int ready_mode, input bit hold,
                          input int exp_lat, input int abort_at, input bit exp_err);
    wr_t  q[$];
    wr_t  exp_w, held;
    bit   stalled = 1'b0;
    bit   seen    = 1'b0;
    int   writes  = 0;
    logic [3:0] d;
    if (!exp_err) begin
      for (int r = 0; r < 7; r++) begin
        for (int c = 0; c < 7; c++) begin
          d = texel(wall, special, 6'(48 - (7 * r + c)));
          if (!(transp && d == 4'h0))
            q.push_back('{x: 7'(int'(col) * 7 + c), y: 6'(int'(row) * 7 + r), d: d});
        end
      end
    end
    req_col     = col;
    req_row     = row;
    req_wall    = wall;
    req_special = special;
    req_transp  = transp;
    req_valid   = 1'b1;
    wr_ready    = 1'b1;
    #1;
    check("accept_ready", req_ready, 1);
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      wr_ready = (ready_mode == 0) ? 1'b1 : 1'(k % 2);
      #1;
      check("busy_not_ready", req_ready, 0);
      if (stalled) begin
        check("stall_valid", wr_valid, 1);
        check("stall_hold", {wr_x, wr_y, wr_data}, held);
      end
      if (abort_at >= 0 && writes == abort_at && wr_valid) begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_wr_valid", wr_valid, 0);
        check("rst_ready", req_ready, 1);
        check("rst_done", done, 0);
        check("rst_wall_sel", tex_wall_sel, 0);
        check("rst_pos", tex_pos, 48);
        seen = 1'b1;
        break;
      end
      if (done) begin
        check("done_no_write", wr_valid, 0);
        check("done_err", err, exp_err);
        if (exp_lat >= 0) check("latency", k, exp_lat);
        seen = 1'b1;
        break;
      end
      check("no_err_busy", err, 0);
      check("wall_sel", tex_wall_sel, wall);
      check("special_sel", tex_special_sel, special);
      if (wr_valid && wr_ready) begin
        if (q.size() == 0) begin
          check("extra_write", writes, 49);
        end else begin
          exp_w = q.pop_front();
          check("write", {wr_x, wr_y, wr_data}, exp_w);
        end
        writes++;
      end
      stalled = wr_valid && !wr_ready;
      held    = '{x: wr_x, y: wr_y, d: wr_data};
    end
    check("done_seen", seen, 1);
    if (abort_at < 0) begin
      check("writes_left", q.size(), 0);
      @(negedge clk);
      #1;
      check("done_pulse", done, 0);
      check("err_pulse", err, 0);
      check("idle_ready", req_ready, 1);
      check("idle_no_write", wr_valid, 0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_col     = '0;
    req_row     = '0;
    req_wall    = '0;
    req_special = '0;
    req_transp  = 1'b0;
    wr_ready    = 1'b0;
    #12;
    @(negedge clk);
    #1;
    check("reset_ready", req_ready, 1);
    check("reset_wr_valid", wr_valid, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_pos", tex_pos, 48);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Opaque wall 15 at the origin, ready tied high.
    run_tile(4'd0, 4'd0, 4'd15, 3'd0, 1'b0, 0, 1'b0, 50, -1, 1'b0);
    // Transparent heart in the bottom-right tile.
    run_tile(4'd12, 4'd8, 4'd0, 3'd2, 1'b1, 0, 1'b0, 50, -1, 1'b0);
    // Backpressure: ready toggles every cycle.
    run_tile(4'd3, 4'd2, 4'd7, 3'd0, 1'b0, 1, 1'b0, -1, -1, 1'b0);
    // Out-of-range column, then out-of-range row.
    run_tile(4'd13, 4'd0, 4'd15, 3'd0, 1'b0, 0, 1'b0, 1, -1, 1'b1);
    run_tile(4'd0, 4'd9, 4'd15, 3'd0, 1'b0, 0, 1'b0, 1, -1, 1'b1);
    // Fully transparent empty tile: full walk, no writes.
    run_tile(4'd5, 4'd5, 4'd0, 3'd0, 1'b1, 0, 1'b0, 50, -1, 1'b0);
    // Wall and special both set: wall texture wins.
    run_tile(4'd2, 4'd3, 4'd9, 3'd2, 1'b0, 0, 1'b0, 50, -1, 1'b0);
    // Reset at texel 20, then the same tile again from the top-left texel.
    run_tile(4'd1, 4'd1, 4'd5, 3'd0, 1'b0, 0, 1'b0, -1, 20, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_tile(4'd1, 4'd1, 4'd5, 3'd0, 1'b0, 0, 1'b0, 50, -1, 1'b0);
    // req_valid held across two back-to-back tiles.
    run_tile(4'd4, 4'd4, 4'd3, 3'd0, 1'b0, 0, 1'b1, 50, -1, 1'b0);
    run_tile(4'd6, 4'd6, 4'd0, 3'd1, 1'b1, 0, 1'b0, 50, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
